// File: rtl/control_sequencer.sv
// Fetch/execute phase sequencer with memory wait states, run/step/breakpoint debug control and a retired-instruction counter.
// Phase/ecount/instr_count change on the falling clock edge; ctrl_en is combinational so a wait state blocks writes in the same cycle.
module control_sequencer #(
    parameter int IW       = 8,
    parameter int AW       = 8,
    parameter int MAX_EXEC = 4,
    parameter int EW       = $clog2(MAX_EXEC + 1),
    parameter int CW       = 16,
    parameter logic [IW-1:0] HLT_OP = IW'(8'h0F)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [IW-1:0] I,
    input  logic [EW-1:0] exec_len,
    input  logic          mem_access,
    input  logic          mem_ready,
    input  logic          run,
    input  logic          step,
    input  logic          bp_en,
    input  logic [AW-1:0] bp_addr,
    input  logic [AW-1:0] pc,
    output logic [2:0]    phase,
    output logic [EW-1:0] ecount,
    output logic          ctrl_en,
    output logic          ir_we,
    output logic [CW-1:0] instr_count,
    output logic          dbg_F0,
    output logic          dbg_halt,
    output logic          dbg_paused
);

    typedef enum logic [2:0] {
        PAUSE = 3'd0,
        F0    = 3'd1,
        F1    = 3'd2,
        EX    = 3'd3,
        HLT   = 3'd7
    } phase_t;

    localparam logic [EW-1:0] LEN_ONE = EW'(1);
    localparam logic [EW-1:0] LEN_MAX = EW'(MAX_EXEC);

    phase_t        phase_q;
    logic [EW-1:0] ecount_q;
    logic [CW-1:0] count_q;
    logic          bp_skip_q;
    logic          step_mode_q;
    logic          step_q;

    logic [EW-1:0] eff_len;
    logic [EW-1:0] last_idx;
    logic [CW-1:0] count_inc;
    logic          step_rise;
    logic          is_halt;
    logic          ex_wait;
    logic          bp_hit;

    always_comb begin
        eff_len = exec_len;
        if (exec_len == '0) begin
            eff_len = LEN_ONE;
        end else if (exec_len > LEN_MAX) begin
            eff_len = LEN_MAX;
        end
    end

    assign last_idx  = eff_len - LEN_ONE;
    assign count_inc = (count_q == '1) ? count_q : count_q + CW'(1);
    assign step_rise = step & ~step_q;
    assign is_halt   = (I == HLT_OP);
    assign ex_wait   = mem_access & ~mem_ready;
    assign bp_hit    = bp_en & (pc == bp_addr) & ~bp_skip_q;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            phase_q     <= PAUSE;
            ecount_q    <= '0;
            count_q     <= '0;
            bp_skip_q   <= 1'b0;
            step_mode_q <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            step_q <= step;
            case (phase_q)
                PAUSE: begin
                    if (step_rise) begin
                        phase_q     <= F0;
                        step_mode_q <= 1'b1;
                    end else if (run) begin
                        phase_q     <= F0;
                        step_mode_q <= 1'b0;
                    end
                end
                F0: begin
                    // Breakpoint wins over a memory wait; bp_skip lets the resume pass it once.
                    if (bp_hit) begin
                        phase_q   <= PAUSE;
                        bp_skip_q <= 1'b1;
                    end else if (mem_ready) begin
                        phase_q <= F1;
                    end
                end
                F1: begin
                    phase_q   <= EX;
                    ecount_q  <= '0;
                    bp_skip_q <= 1'b0;
                end
                EX: begin
                    if (is_halt) begin
                        phase_q <= HLT;
                        count_q <= count_inc;
                    end else if (!ex_wait) begin
                        if (ecount_q == last_idx) begin
                            count_q  <= count_inc;
                            ecount_q <= '0;
                            phase_q  <= (step_mode_q || !run) ? PAUSE : F0;
                        end else begin
                            ecount_q <= ecount_q + LEN_ONE;
                        end
                    end
                end
                HLT: begin
                    phase_q <= HLT;
                end
                default: begin
                    phase_q <= PAUSE;
                end
            endcase
        end
    end

    always_comb begin
        ctrl_en = 1'b0;
        case (phase_q)
            F1:      ctrl_en = 1'b1;
            EX:      ctrl_en = ~is_halt & ~ex_wait;
            default: ctrl_en = 1'b0;
        endcase
    end

    assign phase       = phase_q;
    assign ecount      = ecount_q;
    assign ir_we       = (phase_q == F1);
    assign instr_count = count_q;
    assign dbg_F0      = (phase_q == F0);
    assign dbg_halt    = (phase_q == HLT);
    assign dbg_paused  = (phase_q == PAUSE);

endmodule
